// File: rtl/prefix_subtractor_ks_pipe.sv
// prefix_subtractor_ks_pipe
// Pipelined Kogge-Stone subtractor: diff = a - b - bin (mod 2^WIDTH), bout = borrow.
// Evaluated as a + ~b + ~bin through a registered parallel-prefix carry tree,
// one prefix level per stage, with a global valid/ready stall.
// Optional feature macro: SUB_SIGNED_OVF_EN adds a registered two's-complement
// overflow output 'ovf'.
module prefix_subtractor_ks_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int LEVELS = $clog2(WIDTH);

    // Stage 0 holds the per-bit terms, stage k (1..LEVELS) holds prefix level k.
    logic [WIDTH-1:0] p_q  [0:LEVELS];
    logic [WIDTH-1:0] g_q  [0:LEVELS];
    logic [WIDTH-1:0] pp_q [0:LEVELS];
    logic [LEVELS:0]  cin_q;
    logic [LEVELS:0]  v_q;

    logic [WIDTH-1:0] g_n  [1:LEVELS];
    logic [WIDTH-1:0] pp_n [1:LEVELS];

    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic             cin_in;
    logic [WIDTH-1:0] diff_n;
    logic             bout_n;
    logic             adv;

    // The whole pipe moves together; a held output freezes every stage.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~rst;

    // Per-bit propagate/generate of a + ~b, with the carry-in folded into bit 0
    // so the prefix tree never needs a separate carry-in path.
    always_comb begin
        cin_in  = ~bin;
        p_in    = a ^ ~b;
        g_in    = a & ~b;
        g_in[0] = (a[0] & ~b[0]) | (p_in[0] & cin_in);
    end

    // Kogge-Stone levels: bit i merges with bit i - 2^(k-1) when it exists.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int DIST = 1 << (k - 1);
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= DIST) begin : g_cmb
                assign g_n[k][i]  = g_q[k-1][i] | (pp_q[k-1][i] & g_q[k-1][i-DIST]);
                assign pp_n[k][i] = pp_q[k-1][i] & pp_q[k-1][i-DIST];
            end else begin : g_pass
                assign g_n[k][i]  = g_q[k-1][i];
                assign pp_n[k][i] = pp_q[k-1][i];
            end
        end
    end

    // Sum bit i uses the carry out of bits [i-1:0]; bit 0 uses the carry-in.
    // A carry out of the top bit means no borrow.
    always_comb begin
        diff_n = p_q[LEVELS] ^ {g_q[LEVELS][WIDTH-2:0], cin_q[LEVELS]};
        bout_n = ~g_q[LEVELS][WIDTH-1];
    end

`ifdef SUB_SIGNED_OVF_EN
    logic [LEVELS:0] amsb_q;
    logic [LEVELS:0] bmsb_q;
    logic            ovf_n;

    // Signed overflow: operands of differing sign and a result sign unlike a.
    always_comb begin
        ovf_n = (amsb_q[LEVELS] != bmsb_q[LEVELS]) && (diff_n[WIDTH-1] != amsb_q[LEVELS]);
    end

    // Operand sign bits travel with the beat, under the same stall and reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            amsb_q <= '0;
            bmsb_q <= '0;
            ovf    <= 1'b0;
        end else if (adv) begin
            amsb_q <= {amsb_q[LEVELS-1:0], a[WIDTH-1]};
            bmsb_q <= {bmsb_q[LEVELS-1:0], b[WIDTH-1]};
            ovf    <= ovf_n;
        end
    end
`endif

    // Pipeline registers: only valid bits and outputs need clearing; stage data
    // is don't-care while its valid bit is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
        end else if (adv) begin
            v_q     <= {v_q[LEVELS-1:0], in_valid};
            cin_q   <= {cin_q[LEVELS-1:0], cin_in};
            p_q[0]  <= p_in;
            g_q[0]  <= g_in;
            pp_q[0] <= p_in;
            for (int k = 1; k <= LEVELS; k++) begin
                p_q[k]  <= p_q[k-1];
                g_q[k]  <= g_n[k];
                pp_q[k] <= pp_n[k];
            end
            out_valid <= v_q[LEVELS];
            diff      <= diff_n;
            bout      <= bout_n;
        end
    end

endmodule
